// File: rtl/stream_parity_accum.sv
// stream_parity_accum: two-stage streaming parity accumulator.
// Per beat f = a ^ b ^ (c & d) is registered in S1, then XOR-accumulated into
// the open frame; the last beat of a frame loads a result register that is
// offered on a valid/ready output together with the beat count and overflow.
// Optional feature macro: PARITY_ERR_CNT_EN adds in_exp_parity / err_count,
// counting output transfers whose parity differs from the expected bit.
module stream_parity_accum #(
  parameter int WIDTH  = 8,
  parameter int CNT_W  = 8,
  parameter bit INVERT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             in_last,
`ifdef PARITY_ERR_CNT_EN
  input  logic             in_exp_parity,
  output logic [15:0]      err_count,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_syndrome,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_beats,
  output logic             out_overflow
);

  logic             s1_v;
  logic             s1_last;
  logic [WIDTH-1:0] s1_f;

  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf;

  logic             res_v;
  logic [WIDTH-1:0] res_syn;
  logic [CNT_W-1:0] res_beats;
  logic             res_ovf;

  logic             s1_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic             cnt_full;
  logic [CNT_W-1:0] cnt_next;

  // Handshake decode: only a last beat can stall, and only on a full, undrained result.
  always_comb begin
    s1_adv   = s1_v & (~s1_last | ~res_v | out_ready);
    in_ready = ~s1_v | s1_adv;
    in_xfer  = in_valid & in_ready;
    out_xfer = res_v & out_ready;
    cnt_full = &cnt;
    cnt_next = cnt_full ? cnt : cnt + CNT_W'(1);
  end

  // Stage 1: capture the per-beat function and frame delimiter.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v    <= 1'b0;
      s1_last <= 1'b0;
      s1_f    <= '0;
    end else if (in_xfer) begin
      s1_v    <= 1'b1;
      s1_last <= in_last;
      s1_f    <= in_a ^ in_b ^ (in_c & in_d);
    end else if (s1_adv) begin
      s1_v    <= 1'b0;
    end
  end

  // Open-frame accumulator; cleared as the last beat hands its total to the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (s1_adv) begin
      if (s1_last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc ^ s1_f;
        cnt <= cnt_next;
        ovf <= ovf | cnt_full;
      end
    end
  end

  // Result register: a new frame reloads it even in the cycle the old one drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_v     <= 1'b0;
      res_syn   <= '0;
      res_beats <= '0;
      res_ovf   <= 1'b0;
    end else if (s1_adv && s1_last) begin
      res_v     <= 1'b1;
      res_syn   <= acc ^ s1_f;
      res_beats <= cnt_next;
      res_ovf   <= ovf | cnt_full;
    end else if (out_xfer) begin
      res_v     <= 1'b0;
    end
  end

  // Output view of the result register.
  always_comb begin
    out_valid    = res_v;
    out_syndrome = res_syn;
    out_parity   = (^res_syn) ^ INVERT;
    out_beats    = res_beats;
    out_overflow = res_ovf;
  end

`ifdef PARITY_ERR_CNT_EN
  logic s1_exp;
  logic res_exp;

  // Expected parity rides alongside S1 and the result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_exp  <= 1'b0;
      res_exp <= 1'b0;
    end else begin
      if (in_xfer) s1_exp <= in_exp_parity;
      if (s1_adv && s1_last) res_exp <= s1_exp;
    end
  end

  // Saturating count of delivered frames whose parity disagrees with expectation.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (out_xfer && (out_parity != res_exp) && !(&err_count)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_parity_accum.sv
// tb_stream_parity_accum: directed checks of stream_parity_accum with
// hand-computed syndromes (CNT_W=2 so saturation is reachable quickly).
module tb_stream_parity_accum;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a, in_b, in_c, in_d;
  logic       in_last;
  logic       in_exp_parity;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_syndrome;
  logic       out_parity;
  logic [1:0] out_beats;
  logic       out_overflow;
`ifdef PARITY_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stream_parity_accum #(
    .WIDTH (8),
    .CNT_W (2),
    .INVERT(1'b0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_c         (in_c),
    .in_d         (in_d),
    .in_last      (in_last),
`ifdef PARITY_ERR_CNT_EN
    .in_exp_parity(in_exp_parity),
    .err_count    (err_count),
`endif
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_syndrome (out_syndrome),
    .out_parity   (out_parity),
    .out_beats    (out_beats),
    .out_overflow (out_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                       input logic [7:0] d, input logic last, input logic exp);
    in_a = a; in_b = b; in_c = c; in_d = d;
    in_last = last; in_exp_parity = exp;
    in_valid = 1'b1;
  endtask

  // Present one beat (f = a here) and hold it until accepted.
  task automatic send(input logic [7:0] a, input logic last, input logic exp);
    int n;
    drive(a, 8'h00, 8'h00, 8'h00, last, exp);
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("send_timeout", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    check("out_wait", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_c = '0; in_d = '0; in_last = 1'b0; in_exp_parity = 1'b0;
    tick();
    tick();
    check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_syndrome",  {24'd0, out_syndrome}, 32'd0);
    check("rst_parity",    {31'd0, out_parity}, 32'd0);
    check("rst_beats",     {30'd0, out_beats}, 32'd0);
    check("rst_overflow",  {31'd0, out_overflow}, 32'd0);
`ifdef PARITY_ERR_CNT_EN
    check("rst_err_count", {16'd0, err_count}, 32'd0);
`endif
    rst = 1'b0;

    // Single-beat frame: f = 0x0F ^ 0x33 ^ (0xFF & 0xAA) = 0x96.
    drive(8'h0F, 8'h33, 8'hFF, 8'hAA, 1'b1, 1'b0);
    tick();
    in_valid = 1'b0;
    check("sb_not_early", {31'd0, out_valid}, 32'd0);
    tick();
    check("sb_valid",    {31'd0, out_valid}, 32'd1);
    check("sb_syndrome", {24'd0, out_syndrome}, 32'h96);
    check("sb_parity",   {31'd0, out_parity}, 32'd0);
    check("sb_beats",    {30'd0, out_beats}, 32'd1);
    check("sb_overflow", {31'd0, out_overflow}, 32'd0);
    tick();
    check("sb_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    tick();
    check("sb_drained", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Back-to-back frames with the sink stalled: 3-beat (0x07) then 1-beat (0x10).
    drive(8'h01, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(8'h02, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0); tick();
    drive(8'h04, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); tick();
    drive(8'h10, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); tick();
    check("bb_valid",    {31'd0, out_valid}, 32'd1);
    check("bb_syndrome", {24'd0, out_syndrome}, 32'h07);
    check("bb_beats",    {30'd0, out_beats}, 32'd3);
    check("bb_in_ready", {31'd0, in_ready}, 32'd0);
    drive(8'h20, 8'h00, 8'h00, 8'h00, 1'b1, 1'b0); tick();
    check("stall_in_ready", {31'd0, in_ready}, 32'd0);
    check("stall_syndrome", {24'd0, out_syndrome}, 32'h07);
    out_ready = 1'b1;
    #1;
    check("drain_in_ready", {31'd0, in_ready}, 32'd1);
    check("drain1_syn",     {24'd0, out_syndrome}, 32'h07);
    tick();
    in_valid = 1'b0;
    check("drain2_valid", {31'd0, out_valid}, 32'd1);
    check("drain2_syn",   {24'd0, out_syndrome}, 32'h10);
    check("drain2_beats", {30'd0, out_beats}, 32'd1);
    check("drain2_par",   {31'd0, out_parity}, 32'd1);
    tick();
    check("drain3_valid", {31'd0, out_valid}, 32'd1);
    check("drain3_syn",   {24'd0, out_syndrome}, 32'h20);
    tick();
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    // Saturation with CNT_W=2: 5 beats -> beats=3, overflow=1, syndrome 0x1F.
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h04, 1'b0, 1'b0);
    send(8'h08, 1'b0, 1'b0);
    send(8'h10, 1'b1, 1'b0);
    wait_out();
    check("sat_syndrome", {24'd0, out_syndrome}, 32'h1F);
    check("sat_beats",    {30'd0, out_beats}, 32'd3);
    check("sat_overflow", {31'd0, out_overflow}, 32'd1);
    check("sat_parity",   {31'd0, out_parity}, 32'd1);
    send(8'h03, 1'b0, 1'b0);
    send(8'h05, 1'b1, 1'b0);
    wait_out();
    check("post_sat_syn",   {24'd0, out_syndrome}, 32'h06);
    check("post_sat_beats", {30'd0, out_beats}, 32'd2);
    check("post_sat_ovf",   {31'd0, out_overflow}, 32'd0);
    tick();

    // Reset mid-frame: the two open beats must not reach the next result.
    send(8'h55, 1'b0, 1'b0);
    send(8'h0F, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    send(8'h3C, 1'b1, 1'b0);
    wait_out();
    check("mid_rst_syn",   {24'd0, out_syndrome}, 32'h3C);
    check("mid_rst_beats", {30'd0, out_beats}, 32'd1);
    check("mid_rst_ovf",   {31'd0, out_overflow}, 32'd0);
    tick();

`ifdef PARITY_ERR_CNT_EN
    // Parities 1,0,1,0 against expected 1,1,1,1: frames 2 and 4 mismatch.
    send(8'h01, 1'b1, 1'b1);
    send(8'h03, 1'b1, 1'b1);
    send(8'h07, 1'b1, 1'b1);
    send(8'h0F, 1'b1, 1'b1);
    repeat (4) tick();
    check("err_count", {16'd0, err_count}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
